nf_uart2bus: RTL and testbench
==============================

Name: nf_uart2bus

Overview:
- UART-driven bus initiator (debug/loader master) for the nanoFOX peripheral bus.
- Receives 8N1 command frames on uart_rx, issues single-word bus writes or reads on addr/we/wd/rd, and answers on uart_tx.
- Sits at the opposite end of the peripheral-side UART: a host PC drives the SoC bus without the CPU.
- Self-contained bit-level rx and tx logic; baud rate fixed at elaboration.

Parameters:
- COMP, 16'd434, bit period in clk cycles (50 MHz / 115200); legal range 4..65535.
- TIMEOUT, 16, idle bit periods allowed between bytes of one frame before the frame is discarded.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- addr  output  32  bus address
- we  output  1  bus write enable, one-cycle pulse
- wd  output  32  bus write data
- rd  input  32  bus read data
- uart_rx  input  1  UART rx line, idle high, asynchronous to clk
- uart_tx  output  1  UART tx line, idle high
- busy  output  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset is asynchronous and active-high. Reset values: uart_tx=1, addr=0, wd=0, we=0, busy=0; FSM=IDLE; rx/tx engines idle.
- Rx engine:
  - uart_rx passes through a 2-flop synchroniser.
  - A falling edge starts a byte. The line is re-checked at COMP/2 (integer division); if high, it is a glitch and is ignored.
  - Data is then sampled every COMP cycles: 8 bits LSB first, then the stop bit.
  - Stop bit 0 is a framing error: the byte is dropped and the FSM returns to IDLE.
  - A valid byte yields a one-cycle rx_strobe after stop-bit sampling.
- Tx engine: 8N1, LSB first, each bit held exactly COMP cycles. It accepts a byte only when idle and asserts tx_done one cycle after the stop bit ends.
- Frame format (bytes MSB first):
  - Write: 0x57, A3..A0, D3..D0 -> bus write -> reply 0x4B.
  - Read: 0x52, A3..A0 -> bus read -> reply R3..R0.
  - Any other first byte is ignored; the FSM stays in IDLE and sends no reply.
- FSM states:
  - IDLE: on rx_strobe with 0x57 or 0x52, latch the command and go to GET_ADDR.
  - GET_ADDR: shift 4 bytes into the address shift register. After the 4th, go to GET_DATA for a write or BUS_RD for a read.
  - GET_DATA: shift 4 bytes into the data register, then go to BUS_WR.
  - BUS_WR: drive addr and wd; we=1 for exactly one cycle; then go to SEND_ACK.
  - BUS_RD: drive addr with we=0 for one cycle; capture rd on the following cycle (RD_CAPT); then go to SEND_DATA.
  - SEND_ACK: transmit 0x4B, then go to IDLE on tx_done.
  - SEND_DATA: transmit 4 bytes MSB first, back-to-back (the next byte is loaded on tx_done); go to IDLE after the 4th.
- Timing rules:
  - addr changes only on entry to BUS_WR/BUS_RD and holds its value afterwards.
  - wd changes only on entry to BUS_WR.
  - we is never high outside BUS_WR.
- Timeout: in GET_ADDR or GET_DATA, if no rx_strobe arrives for TIMEOUT*COMP cycles, the FSM returns to IDLE with no bus access and no reply. The counter restarts on every rx_strobe.
- Bytes received in any state other than IDLE, GET_ADDR or GET_DATA are discarded; there is no buffering.
- The rx engine keeps running while tx is active.
- Reset asserted mid-frame or mid-transmission: uart_tx goes to 1 immediately and the partial frame is lost.

Test Plan:
- COMP=8; send 57 00 00 00 10 DE AD BE EF -> exactly one cycle with we=1, addr=0x00000010, wd=0xDEADBEEF; uart_tx returns 0x4B; busy falls after its stop bit.
- COMP=8; send 52 00 00 00 04; rd model returns 0x12345678 when addr==4 -> uart_tx bytes 12 34 56 78 back-to-back, each bit 8 cycles; we stays 0 throughout.
- Send 0xA5 then a valid write frame -> 0xA5 ignored with no tx activity; write executes normally.
- Send 57 00 00, then idle for 17*COMP cycles, then 52 00 00 00 00 -> no write occurs; read of addr 0 completes.
- 1-cycle low glitch on uart_rx, and a byte with stop bit 0 -> no rx_strobe for either; FSM remains IDLE.
- Assert reset during the 2nd reply byte of a read -> uart_tx=1, addr=0, busy=0 immediately; a following write frame executes correctly.

Source files
------------

// File: rtl/nf_uart2bus.sv
// UART-driven bus initiator: 8N1 command frames on uart_rx become single-word
// bus writes/reads, answered on uart_tx (0x4B ack or four read-data bytes).
module nf_uart2bus #(
  parameter logic [15:0] COMP    = 16'd434,
  parameter int          TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  output logic        we,
  output logic [31:0] wd,
  input  logic [31:0] rd,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        busy
);

  localparam logic [15:0] HALF   = COMP >> 1;
  localparam logic [31:0] TO_CYC = 32'(TIMEOUT) * {16'd0, COMP};

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAPT,
                            SEND_ACK, SEND_DATA} st_t;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_st_t      rx_st_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_stb_q, rx_ferr_q;

  logic        tx_busy_q, tx_q, tx_done_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [8:0]  tx_sh_q;

  st_t         st_q;
  logic        is_wr_q, tx_start_q, we_q;
  logic [1:0]  cnt_q;
  logic [31:0] sh_q, addr_hold_q, addr_q, wd_q, to_cnt_q;
  logic [7:0]  tx_byte_q;

  assign addr    = addr_q;
  assign wd      = wd_q;
  assign we      = we_q;
  assign uart_tx = tx_q;
  assign busy    = (st_q != IDLE);

  // Receiver: mid-bit sampling, half-period re-check rejects start glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_stb_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_stb_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_q <= HALF - 16'd1;
          rx_st_q  <= RX_START;
        end
        RX_START: if (rx_cnt_q != 16'd0) rx_cnt_q <= rx_cnt_q - 16'd1;
          else if (rx_s2_q) rx_st_q <= RX_IDLE;
          else begin
            rx_cnt_q <= COMP - 16'd1;
            rx_bit_q <= 3'd0;
            rx_st_q  <= RX_DATA;
          end
        RX_DATA: if (rx_cnt_q != 16'd0) rx_cnt_q <= rx_cnt_q - 16'd1;
          else begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_cnt_q <= COMP - 16'd1;
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end
        default: if (rx_cnt_q != 16'd0) rx_cnt_q <= rx_cnt_q - 16'd1;
          else begin
            rx_stb_q  <= rx_s2_q;
            rx_ferr_q <= !rx_s2_q;
            rx_st_q   <= RX_IDLE;
          end
      endcase
    end
  end

  // Transmitter: tx_sh_q holds data plus stop bit; start bit is driven on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy_q <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (tx_start_q) begin
          tx_busy_q <= 1'b1;
          tx_q      <= 1'b0;
          tx_sh_q   <= {1'b1, tx_byte_q};
          tx_cnt_q  <= COMP - 16'd1;
          tx_bit_q  <= 4'd9;
        end
      end else if (tx_cnt_q != 16'd0) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else if (tx_bit_q == 4'd0) begin
        tx_busy_q <= 1'b0;
        tx_done_q <= 1'b1;
      end else begin
        tx_q     <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
        tx_bit_q <= tx_bit_q - 4'd1;
        tx_cnt_q <= COMP - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= IDLE;
      is_wr_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_hold_q <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      to_cnt_q    <= '0;
      tx_byte_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (st_q)
        IDLE: if (rx_stb_q && (rx_sh_q == 8'h57 || rx_sh_q == 8'h52)) begin
          is_wr_q  <= (rx_sh_q == 8'h57);
          cnt_q    <= 2'd0;
          to_cnt_q <= TO_CYC - 32'd1;
          st_q     <= GET_ADDR;
        end
        GET_ADDR, GET_DATA: begin
          if (rx_ferr_q) st_q <= IDLE;
          else if (rx_stb_q) begin
            sh_q     <= {sh_q[23:0], rx_sh_q};
            to_cnt_q <= TO_CYC - 32'd1;
            cnt_q    <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (st_q == GET_DATA) begin
                addr_q <= addr_hold_q;
                wd_q   <= {sh_q[23:0], rx_sh_q};
                we_q   <= 1'b1;
                st_q   <= BUS_WR;
              end else if (is_wr_q) begin
                addr_hold_q <= {sh_q[23:0], rx_sh_q};
                st_q        <= GET_DATA;
              end else begin
                addr_q <= {sh_q[23:0], rx_sh_q};
                st_q   <= BUS_RD;
              end
            end
          end else if (to_cnt_q == 32'd0) st_q <= IDLE;
          else to_cnt_q <= to_cnt_q - 32'd1;
        end
        BUS_WR: begin
          we_q       <= 1'b0;
          tx_byte_q  <= 8'h4B;
          tx_start_q <= 1'b1;
          st_q       <= SEND_ACK;
        end
        BUS_RD: st_q <= RD_CAPT;
        RD_CAPT: begin
          tx_byte_q  <= rd[31:24];
          sh_q       <= {rd[23:0], 8'h00};
          tx_start_q <= 1'b1;
          cnt_q      <= 2'd0;
          st_q       <= SEND_DATA;
        end
        SEND_ACK: if (tx_done_q) st_q <= IDLE;
        default: if (tx_done_q) begin
          if (cnt_q == 2'd3) st_q <= IDLE;
          else begin
            cnt_q      <= cnt_q + 2'd1;
            tx_byte_q  <= sh_q[31:24];
            sh_q       <= {sh_q[23:0], 8'h00};
            tx_start_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_uart2bus.sv
// Scoreboard bench for nf_uart2bus: stimulus pushes expected bus writes and tx
// bytes into queues; independent monitors decode uart_tx / we and compare.
module tb_nf_uart2bus;
  localparam int COMP = 8;

  logic        clk, reset, we, uart_rx, uart_tx, busy;
  logic [31:0] addr, wd, rd;

  logic [63:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  int          n_pass = 0, n_total = 0, n_txb = 0;
  logic        tx_abort = 1'b0;

  nf_uart2bus #(.COMP(16'd8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rd = 32'h0;
    if (addr == 32'h4) rd = 32'h12345678;
    else if (addr == 32'h0) rd = 32'hCAFEF00D;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bus monitor: every cycle with we high must match a queued write.
  initial forever begin
    @(negedge clk);
    if (we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %h wd %h, none expected", addr, wd);
      end else check("bus_write", {addr, wd}, exp_wr.pop_front());
    end
  end

  // Tx monitor: decode 8N1 at mid-bit, compare {stop,data} against queue.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && uart_tx === 1'b0) begin
        repeat (COMP/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (COMP) @(negedge clk);
          d[i] = uart_tx;
        end
        repeat (COMP) @(negedge clk);
        if (tx_abort) tx_abort = 1'b0;
        else if (exp_tx.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_tx: byte %h stop %b, none expected", d, uart_tx);
        end else check("tx_byte", {55'd0, uart_tx, d}, {55'd0, 1'b1, exp_tx.pop_front()});
        n_txb++;
      end
      prev = uart_tx;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (COMP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (COMP) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (COMP) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
  endtask

  task automatic send_rd(input logic [31:0] a);
    send_byte(8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_total++;
      $display("FAIL %s_timeout: busy %b after %0d cycles, required 0", name, busy, n);
    end
    repeat (2*COMP) @(negedge clk);
    check({name, "_tx_drained"}, 64'(exp_tx.size()), 64'd0);
    check({name, "_wr_drained"}, 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    int n;
    uart_rx = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 64'(uart_tx), 64'd1);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wd", 64'(wd), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write frame with ack.
    exp_wr.push_back({32'h00000010, 32'hDEADBEEF});
    exp_tx.push_back(8'h4B);
    send_wr(32'h10, 32'hDEADBEEF);
    wait_idle("write1");
    check("write1_addr_held", 64'(addr), 64'h10);

    // Read frame: four reply bytes MSB first.
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send_rd(32'h4);
    wait_idle("read4");

    // Unknown command byte is ignored, then a normal write.
    send_byte(8'hA5, 1'b1);
    repeat (4*COMP) @(negedge clk);
    check("a5_ignored_busy", 64'(busy), 64'd0);
    exp_wr.push_back({32'h00000020, 32'h11223344});
    exp_tx.push_back(8'h4B);
    send_wr(32'h20, 32'h11223344);
    wait_idle("write2");

    // Partial frame times out; following read of address 0 completes.
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    check("partial_busy", 64'(busy), 64'd1);
    repeat (17*COMP) @(negedge clk);
    check("timeout_busy", 64'(busy), 64'd0);
    exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
    send_rd(32'h0);
    wait_idle("read0");

    // Start-bit glitch and framing error both leave the FSM idle.
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (2*COMP) @(negedge clk);
    check("glitch_busy", 64'(busy), 64'd0);
    send_byte(8'h57, 1'b0);
    repeat (4*COMP) @(negedge clk);
    check("ferr_busy", 64'(busy), 64'd0);

    // Reset while the second reply byte is on the line.
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send_rd(32'h4);
    n = n_txb;
    for (int i = 0; i < 2000 && n_txb == n; i++) @(negedge clk);
    check("mid_read_first_byte_seen", 64'(n_txb), 64'(n + 1));
    repeat (3*COMP) @(negedge clk);
    check("mid_read_addr", 64'(addr), 64'h4);
    check("mid_read_busy", 64'(busy), 64'd1);
    tx_abort = 1'b1;
    exp_tx.delete();
    reset = 1'b1;
    #1;
    check("midrst_uart_tx", 64'(uart_tx), 64'd1);
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12*COMP) @(negedge clk);
    exp_wr.push_back({32'h00000030, 32'hA55A0FF0});
    exp_tx.push_back(8'h4B);
    send_wr(32'h30, 32'hA55A0FF0);
    wait_idle("write3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end
endmodule
